// File: rtl/rst_seq.sv
// rst_seq: synchronises and filters a reset request, stretches it, then releases N_OUT resets in index order
module rst_seq #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_CYCLES  = 3,
  parameter int STRETCH_CYCLES = 8,
  parameter int STAGGER_CYCLES = 4,
  parameter int N_OUT          = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rst_asyn,
  output logic [N_OUT-1:0] rst_main,
  output logic             rst_busy,
  output logic             rst_done,
  output logic [7:0]       rst_cnt
);
  localparam logic [1:0] RUN = 2'd0, ASSERT = 2'd1, RELEASE = 2'd2;
  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int SW = $clog2(STRETCH_CYCLES + 1);
  localparam int GW = $clog2(STAGGER_CYCLES + 1);
  localparam int KW = N_OUT > 1 ? $clog2(N_OUT) : 1;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FW-1:0]          fcnt_q, fcnt_d;
  logic                   acc_q, acc_d;
  logic [1:0]             state_q, state_d;
  logic [SW-1:0]          scnt_q, scnt_d;
  logic [GW-1:0]          gcnt_q, gcnt_d;
  logic [KW-1:0]          k_q, k_d;
  logic [N_OUT-1:0]       main_q, main_d;
  logic                   done_q, done_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   req_s, gstep, last;
  assign req_s  = sync_q[SYNC_STAGES-1];
  assign sync_d = {sync_q[SYNC_STAGES-2:0], rst_asyn};
  assign fcnt_d = !req_s ? '0 : (fcnt_q == FW'(FILTER_CYCLES) ? fcnt_q : fcnt_q + 1'b1);
  // accept is registered so every request reaches the FSM through one flop
  assign acc_d  = fcnt_q == FW'(FILTER_CYCLES);
  assign gstep  = gcnt_q == GW'(STAGGER_CYCLES - 1);
  assign last   = k_q == KW'(N_OUT - 1);
  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    gcnt_d  = gcnt_q;
    k_d     = k_q;
    main_d  = main_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    if (acc_q) begin
      state_d = ASSERT;
      main_d  = '1;
      scnt_d  = '0;
      cnt_d   = (state_q != ASSERT && cnt_q != 8'hff) ? cnt_q + 8'd1 : cnt_q;
    end else if (state_q == ASSERT) begin
      scnt_d = req_s ? '0 : scnt_q + 1'b1;
      if (!req_s && scnt_q == SW'(STRETCH_CYCLES - 1)) begin
        state_d = RELEASE;
        gcnt_d  = '0;
        k_d     = '0;
      end
    end else if (state_q == RELEASE) begin
      gcnt_d = gstep ? '0 : gcnt_q + 1'b1;
      if (gstep) begin
        main_d[k_q] = 1'b0;
        k_d         = last ? k_q : k_q + 1'b1;
        state_d     = last ? RUN : RELEASE;
        done_d      = last;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      fcnt_q  <= '0;
      acc_q   <= 1'b0;
      state_q <= ASSERT;
      scnt_q  <= '0;
      gcnt_q  <= '0;
      k_q     <= '0;
      main_q  <= '1;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      fcnt_q  <= fcnt_d;
      acc_q   <= acc_d;
      state_q <= state_d;
      scnt_q  <= scnt_d;
      gcnt_q  <= gcnt_d;
      k_q     <= k_d;
      main_q  <= main_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end
  assign rst_main = main_q;
  assign rst_busy = state_q != RUN;
  assign rst_done = done_q;
  assign rst_cnt  = cnt_q;
endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: directed and random stimulus for rst_seq against a sample-history model
module tb_rst_seq;
  localparam int SY = 2, FC = 3, ST = 8, SG = 4, N = 3;
  logic clk = 1'b0, rst, rst_asyn;
  logic [N-1:0] rst_main;
  logic rst_busy, rst_done;
  logic [7:0] rst_cnt;
  int vectors = 0, miscompares = 0;
  logic on = 1'b0;
  rst_seq #(.SYNC_STAGES(SY), .FILTER_CYCLES(FC), .STRETCH_CYCLES(ST),
            .STAGGER_CYCLES(SG), .N_OUT(N)) dut (
    .clk(clk), .rst(rst), .rst_asyn(rst_asyn), .rst_main(rst_main),
    .rst_busy(rst_busy), .rst_done(rst_done), .rst_cnt(rst_cnt));
  always #5 clk = ~clk;
  // model: h[i] is rst_asyn as sampled i edges ago; mode 0 run, 1 assert, 2 release
  logic [15:0] h = '0;
  int mode = 1, low = 0, rel_t = 0;
  logic [N-1:0] m_main = '1;
  logic m_done = 1'b0;
  logic [7:0] m_cnt = '0;
  function automatic logic accept(input logic [15:0] hh);
    for (int i = SY + 2; i <= SY + FC + 1; i++) if (!hh[i]) return 1'b0;
    return 1'b1;
  endfunction
  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      h = '0; mode = 1; low = 0; rel_t = 0; m_cnt = '0;
    end else begin
      h = {h[14:0], rst_asyn};
      if (accept(h)) begin
        if (mode != 1 && m_cnt != 8'hff) m_cnt = m_cnt + 8'd1;
        mode = 1; low = 0;
      end else if (mode == 1) begin
        low = h[SY] ? 0 : low + 1;
        if (low == ST) begin mode = 2; rel_t = 0; end
      end else if (mode == 2) begin
        rel_t++;
        if (rel_t == N * SG) begin mode = 0; m_done = 1'b1; end
      end
    end
    for (int k = 0; k < N; k++) m_main[k] = (mode == 1) || (mode == 2 && rel_t < (k + 1) * SG);
  end
  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (on) begin
    chk("model_main", int'(rst_main), int'(m_main));
    chk("model_busy", int'(rst_busy), int'(mode != 0));
    chk("model_done", int'(rst_done), int'(m_done));
    chk("model_cnt", int'(rst_cnt), int'(m_cnt));
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_idle(input int budget);
    int n = 0;
    while ((rst_busy || rst_main != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", int'(n < budget), 1);
  endtask
  initial begin
    rst = 1'b1; rst_asyn = 1'b0;
    @(posedge clk); on = 1'b1;
    cyc(2);
    chk("rst_main", rst_main, 3'b111); chk("rst_busy", rst_busy, 1);
    chk("rst_done", rst_done, 0); chk("rst_cnt", rst_cnt, 0);
    // power-on: release entry 8 edges after rst falls, bits at +4/+8/+12
    rst = 1'b0;
    cyc(8);  chk("po_stretch", rst_main, 3'b111);
    cyc(4);  chk("po_bit0", rst_main, 3'b110);
    cyc(4);  chk("po_bit1", rst_main, 3'b100);
    cyc(4);  chk("po_bit2", rst_main, 3'b000); chk("po_done", rst_done, 1); chk("po_cnt", rst_cnt, 0);
    cyc(1);  chk("po_done_end", rst_done, 0); chk("po_idle", rst_busy, 0);
    // 10-cycle request: all ones after E6, release entry E21
    rst_asyn = 1'b1;
    cyc(6);  chk("lat_e5", rst_main, 3'b000);
    cyc(1);  chk("lat_e6", rst_main, 3'b111); chk("req_cnt", rst_cnt, 1);
    cyc(3);  rst_asyn = 1'b0;
    cyc(12); chk("req_stretch", rst_main, 3'b111); chk("req_busy", rst_busy, 1);
    cyc(3);  chk("req_e24", rst_main, 3'b111);
    cyc(1);  chk("req_e25", rst_main, 3'b110);
    wait_idle(20); chk("req_cnt_end", rst_cnt, 1);
    // glitch of two cycles is ignored
    rst_asyn = 1'b1; cyc(2); rst_asyn = 1'b0;
    cyc(12); chk("gl_main", rst_main, 3'b000); chk("gl_busy", rst_busy, 0); chk("gl_cnt", rst_cnt, 1);
    // exactly FILTER_CYCLES samples accepted, then re-request after bit 0 released
    rst_asyn = 1'b1; cyc(3); rst_asyn = 1'b0;
    cyc(4);  chk("min_acc", rst_main, 3'b111); chk("min_cnt", rst_cnt, 2);
    cyc(8);  chk("min_rel", rst_main, 3'b111);
    rst_asyn = 1'b1;
    cyc(4);  chk("rr_bit0", rst_main, 3'b110); rst_asyn = 1'b0;
    cyc(2);  chk("rr_e20", rst_main, 3'b110);
    cyc(1);  chk("rr_reassert", rst_main, 3'b111); chk("rr_cnt", rst_cnt, 3);
    wait_idle(60);
    // rst during RELEASE with k=1
    rst_asyn = 1'b1; cyc(3); rst_asyn = 1'b0;
    cyc(16); chk("mr_k1", rst_main, 3'b110);
    rst = 1'b1;
    cyc(1);  chk("mr_main", rst_main, 3'b111); chk("mr_cnt", rst_cnt, 0); chk("mr_busy", rst_busy, 1);
    rst = 1'b0;
    wait_idle(40); chk("mr_cnt_end", rst_cnt, 0);
    // saturation of the request counter
    for (int i = 0; i < 300; i++) begin
      rst_asyn = 1'b1; cyc(5); rst_asyn = 1'b0; cyc(20);
    end
    wait_idle(60); chk("sat_cnt", rst_cnt, 255);
    // asynchronous toggling at random offsets
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #($urandom_range(1, 4));
      rst_asyn = 1'($urandom_range(0, 1));
    end
    @(negedge clk); rst_asyn = 1'b0;
    wait_idle(80);
    chk("rand_cnt_sat", rst_cnt, 255);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
